// File: rtl/csr_reg_file_if.sv
// CSR file bus: read port, writeback write port, retire/trap/mret events and status outputs.
interface csr_reg_file_if;
  logic        re_i;
  logic [11:0] raddr_i;
  logic [31:0] rdata_o;
  logic        we_i;
  logic [11:0] waddr_i;
  logic [31:0] wdata_i;
  logic        instret_i;
  logic        trap_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_tval_i;
  logic        mret_i;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mstatus_mie_o;
  logic [31:0] mie_o;
  logic        illegal_o;

  // Pipeline side driving the CSR file.
  modport master (
    output re_i, raddr_i, we_i, waddr_i, wdata_i, instret_i,
           trap_i, trap_pc_i, trap_cause_i, trap_tval_i, mret_i,
    input  rdata_o, mtvec_o, mepc_o, mstatus_mie_o, mie_o, illegal_o
  );

  // The CSR file itself.
  modport slave (
    input  re_i, raddr_i, we_i, waddr_i, wdata_i, instret_i,
           trap_i, trap_pc_i, trap_cause_i, trap_tval_i, mret_i,
    output rdata_o, mtvec_o, mepc_o, mstatus_mie_o, mie_o, illegal_o
  );
endinterface

// File: rtl/csr_reg_file.sv
// Machine-mode CSR register file with 64-bit cycle/instret counters and trap/mret sequencing.
module csr_reg_file (
  input  logic           clk_i,
  input  logic           rst_n_i,
  csr_reg_file_if.slave  bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;
  localparam int unsigned CW   = 64;

  localparam logic [AW-1:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [AW-1:0] ADDR_MISA      = 12'h301;
  localparam logic [AW-1:0] ADDR_MIE       = 12'h304;
  localparam logic [AW-1:0] ADDR_MTVEC     = 12'h305;
  localparam logic [AW-1:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [AW-1:0] ADDR_MEPC      = 12'h341;
  localparam logic [AW-1:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [AW-1:0] ADDR_MTVAL     = 12'h343;
  localparam logic [AW-1:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [AW-1:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [AW-1:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [AW-1:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [AW-1:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [AW-1:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [AW-1:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [AW-1:0] ADDR_INSTRETH  = 12'hC82;

  localparam logic [XLEN-1:0] MISA_VAL   = 32'h4000_0100;
  localparam logic [XLEN-1:0] MIE_MASK   = 32'h0000_0888;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic            mstatus_mie_q, mstatus_mie_n;
  logic            mstatus_mpie_q, mstatus_mpie_n;
  logic [XLEN-1:0] mie_q, mie_n;
  logic [XLEN-1:0] mtvec_q, mtvec_n;
  logic [XLEN-1:0] mscratch_q, mscratch_n;
  logic [XLEN-1:0] mepc_q, mepc_n;
  logic [XLEN-1:0] mcause_q, mcause_n;
  logic [XLEN-1:0] mtval_q, mtval_n;
  logic [CW-1:0]   mcycle_q, mcycle_n;
  logic [CW-1:0]   minstret_q, minstret_n;
  logic [XLEN-1:0] rd_val;
  logic            wr_ok;

  function automatic logic is_impl(input logic [AW-1:0] a);
    case (a)
      ADDR_MSTATUS, ADDR_MISA, ADDR_MIE, ADDR_MTVEC,
      ADDR_MSCRATCH, ADDR_MEPC, ADDR_MCAUSE, ADDR_MTVAL,
      ADDR_MCYCLE, ADDR_MINSTRET, ADDR_MCYCLEH, ADDR_MINSTRETH,
      ADDR_CYCLE, ADDR_INSTRET, ADDR_CYCLEH, ADDR_INSTRETH: is_impl = 1'b1;
      default:                                               is_impl = 1'b0;
    endcase
  endfunction

  function automatic logic is_ro(input logic [AW-1:0] a);
    case (a)
      ADDR_CYCLE, ADDR_INSTRET, ADDR_CYCLEH, ADDR_INSTRETH: is_ro = 1'b1;
      default:                                              is_ro = 1'b0;
    endcase
  endfunction

  assign wr_ok = bus.we_i && is_impl(bus.waddr_i) && !is_ro(bus.waddr_i);

  assign bus.illegal_o = (bus.re_i && !is_impl(bus.raddr_i)) ||
                         (bus.we_i && (!is_impl(bus.waddr_i) || is_ro(bus.waddr_i)));

  // Read mux; current (pre-write) register values only.
  always_comb begin
    rd_val = '0;
    case (bus.raddr_i)
      ADDR_MSTATUS:                  rd_val = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      ADDR_MISA:                     rd_val = MISA_VAL;
      ADDR_MIE:                      rd_val = mie_q;
      ADDR_MTVEC:                    rd_val = mtvec_q;
      ADDR_MSCRATCH:                 rd_val = mscratch_q;
      ADDR_MEPC:                     rd_val = mepc_q;
      ADDR_MCAUSE:                   rd_val = mcause_q;
      ADDR_MTVAL:                    rd_val = mtval_q;
      ADDR_MCYCLE,   ADDR_CYCLE:     rd_val = mcycle_q[31:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:    rd_val = mcycle_q[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:   rd_val = minstret_q[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: rd_val = minstret_q[63:32];
      default:                       rd_val = '0;
    endcase
  end

  assign bus.rdata_o = bus.re_i ? rd_val : '0;

  // Next state: software write first, then mret, then trap, so later sources win.
  always_comb begin
    mstatus_mie_n  = mstatus_mie_q;
    mstatus_mpie_n = mstatus_mpie_q;
    mie_n          = mie_q;
    mtvec_n        = mtvec_q;
    mscratch_n     = mscratch_q;
    mepc_n         = mepc_q;
    mcause_n       = mcause_q;
    mtval_n        = mtval_q;
    mcycle_n       = mcycle_q + CW'(1);
    minstret_n     = bus.instret_i ? minstret_q + CW'(1) : minstret_q;

    if (wr_ok) begin
      case (bus.waddr_i)
        ADDR_MSTATUS: begin
          mstatus_mie_n  = bus.wdata_i[3];
          mstatus_mpie_n = bus.wdata_i[7];
        end
        ADDR_MIE:       mie_n      = bus.wdata_i & MIE_MASK;
        ADDR_MTVEC:     mtvec_n    = bus.wdata_i & ALIGN_MASK;
        ADDR_MSCRATCH:  mscratch_n = bus.wdata_i;
        ADDR_MEPC:      mepc_n     = bus.wdata_i & ALIGN_MASK;
        ADDR_MCAUSE:    mcause_n   = bus.wdata_i;
        ADDR_MTVAL:     mtval_n    = bus.wdata_i;
        ADDR_MCYCLE:    mcycle_n   = {mcycle_q[63:32], bus.wdata_i};
        ADDR_MCYCLEH:   mcycle_n   = {bus.wdata_i, mcycle_q[31:0]};
        ADDR_MINSTRET:  minstret_n = {minstret_q[63:32], bus.wdata_i};
        ADDR_MINSTRETH: minstret_n = {bus.wdata_i, minstret_q[31:0]};
        default: ;
      endcase
    end

    if (bus.mret_i) begin
      mstatus_mie_n  = mstatus_mpie_q;
      mstatus_mpie_n = 1'b1;
    end

    if (bus.trap_i) begin
      mstatus_mpie_n = mstatus_mie_q;
      mstatus_mie_n  = 1'b0;
      mepc_n         = bus.trap_pc_i & ALIGN_MASK;
      mcause_n       = bus.trap_cause_i;
      mtval_n        = bus.trap_tval_i;
    end
  end

  // State registers; reset clears everything asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_n;
      mstatus_mpie_q <= mstatus_mpie_n;
      mie_q          <= mie_n;
      mtvec_q        <= mtvec_n;
      mscratch_q     <= mscratch_n;
      mepc_q         <= mepc_n;
      mcause_q       <= mcause_n;
      mtval_q        <= mtval_n;
      mcycle_q       <= mcycle_n;
      minstret_q     <= minstret_n;
    end
  end

  assign bus.mtvec_o       = mtvec_q;
  assign bus.mepc_o        = mepc_q;
  assign bus.mstatus_mie_o = mstatus_mie_q;
  assign bus.mie_o         = mie_q;
endmodule

// File: tb/tb_csr_reg_file.sv
// Self-checking bench for csr_reg_file: directed scenarios plus random traffic against a CSR model.
module tb_csr_reg_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;
  logic [31:0] last_rdata;

  csr_reg_file_if bus();

  csr_reg_file dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Architectural model of the CSR state.
  logic        m_mie, m_mpie;
  logic [31:0] m_miereg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;

  logic [11:0] addr_tab [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'h7C0, 12'h306,
                                 12'h000, 12'hF11};

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_miereg = 0; m_mtvec = 0; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
  endtask

  function automatic bit m_impl(input logic [11:0] a);
    foreach (addr_tab[i]) if (i < 16 && addr_tab[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    return (a == 12'hC00) || (a == 12'hC02) || (a == 12'hC80) || (a == 12'hC82);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (32'(m_mpie) * 128) + (32'(m_mie) * 8);
      12'h301: return 32'h4000_0100;
      12'h304: return m_miereg;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of architectural effect: write, then mret, then trap override.
  task automatic m_update(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                          input logic ir, input logic tr, input logic [31:0] pc, ca, tv,
                          input logic mr);
    logic nmie, nmpie;
    bit cyc_w, ins_w;
    nmie = m_mie; nmpie = m_mpie; cyc_w = 0; ins_w = 0;
    if (we && m_impl(wa) && !m_ro(wa)) begin
      case (wa)
        12'h300: begin nmie = wd[3]; nmpie = wd[7]; end
        12'h304: m_miereg = wd & 32'h888;
        12'h305: m_mtvec = (wd >> 2) << 2;
        12'h340: m_mscratch = wd;
        12'h341: m_mepc = (wd >> 2) << 2;
        12'h342: m_mcause = wd;
        12'h343: m_mtval = wd;
        12'hB00: begin m_cyc[31:0]  = wd; cyc_w = 1; end
        12'hB80: begin m_cyc[63:32] = wd; cyc_w = 1; end
        12'hB02: begin m_ins[31:0]  = wd; ins_w = 1; end
        12'hB82: begin m_ins[63:32] = wd; ins_w = 1; end
        default: ;
      endcase
    end
    if (mr) begin nmie = m_mpie; nmpie = 1; end
    if (tr) begin
      nmpie = m_mie; nmie = 0;
      m_mepc = (pc >> 2) << 2; m_mcause = ca; m_mtval = tv;
    end
    m_mie = nmie; m_mpie = nmpie;
    if (!cyc_w) m_cyc = m_cyc + 64'd1;
    if (!ins_w && ir) m_ins = m_ins + 64'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.re_i = 0; bus.raddr_i = 0; bus.we_i = 0; bus.waddr_i = 0; bus.wdata_i = 0;
    bus.instret_i = 0; bus.trap_i = 0; bus.trap_pc_i = 0; bus.trap_cause_i = 0;
    bus.trap_tval_i = 0; bus.mret_i = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".mtvec_o"}, bus.mtvec_o, m_mtvec);
    chk({tag, ".mepc_o"}, bus.mepc_o, m_mepc);
    chk({tag, ".mie_o"}, bus.mie_o, m_miereg);
    chk({tag, ".mstatus_mie_o"}, 32'(bus.mstatus_mie_o), 32'(m_mie));
  endtask

  // Drive one cycle, check combinational outputs before the edge and registered ones after.
  task automatic cyc(input logic re, input logic [11:0] ra, input logic we, input logic [11:0] wa,
                     input logic [31:0] wd, input logic ir, input logic tr,
                     input logic [31:0] pc, ca, tv, input logic mr);
    logic exp_ill;
    bus.re_i = re; bus.raddr_i = ra; bus.we_i = we; bus.waddr_i = wa; bus.wdata_i = wd;
    bus.instret_i = ir; bus.trap_i = tr; bus.trap_pc_i = pc; bus.trap_cause_i = ca;
    bus.trap_tval_i = tv; bus.mret_i = mr;
    #1;
    exp_ill = (re && !m_impl(ra)) || (we && (!m_impl(wa) || m_ro(wa)));
    last_rdata = bus.rdata_o;
    chk($sformatf("rdata@%h", ra), bus.rdata_o, re ? m_read(ra) : 32'h0);
    chk("illegal", 32'(bus.illegal_o), 32'(exp_ill));
    @(posedge clk);
    m_update(we, wa, wd, ir, tr, pc, ca, tv, mr);
    #1;
    chk_regs("post");
  endtask

  task automatic rd(input logic [11:0] a);
    cyc(1, a, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cyc(0, 0, 1, a, d, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive_idle();
    m_reset();
    bus.re_i = 1; bus.raddr_i = 12'hB00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rdata_mcycle", bus.rdata_o, 32'h0);
    chk_regs("reset");
    rst_n = 1;
    m_reset();

    // mcycle reads 0 then 1 after reset release
    rd(12'hB00); chk("mcycle_first", last_rdata, 32'h0);
    rd(12'hB00); chk("mcycle_second", last_rdata, 32'h1);

    // mstatus write and readback
    wr(12'h300, 32'h0000_0088);
    chk("mstatus_mie_o_after_write", 32'(bus.mstatus_mie_o), 32'h1);
    rd(12'h300); chk("mstatus_read", last_rdata, 32'h0000_1888);

    // misa, mie mask, mtvec alignment
    wr(12'h301, 32'hFFFF_FFFF);
    rd(12'h301); chk("misa_read", last_rdata, 32'h4000_0100);
    wr(12'h304, 32'hFFFF_FFFF); chk("mie_o_masked", bus.mie_o, 32'h0000_0888);
    wr(12'h305, 32'h0000_1003); chk("mtvec_o_aligned", bus.mtvec_o, 32'h0000_1000);

    // trap entry then mret
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h0000_1236, 32'h2, 32'hDEAD_BEEF, 0);
    chk("trap_mepc_o", bus.mepc_o, 32'h0000_1234);
    chk("trap_mie_o", 32'(bus.mstatus_mie_o), 32'h0);
    rd(12'h300); chk("trap_mstatus", last_rdata, 32'h0000_1880);
    rd(12'h342); chk("trap_mcause", last_rdata, 32'h2);
    rd(12'h343); chk("trap_mtval", last_rdata, 32'hDEAD_BEEF);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rd(12'h300); chk("mret_mstatus", last_rdata, 32'h0000_1888);

    // counter carry on increment only
    wr(12'hB00, 32'hFFFF_FFFF); wr(12'hB80, 32'h0);
    rd(12'hB00); chk("mcycle_loaded", last_rdata, 32'hFFFF_FFFF);
    rd(12'hB80); chk("mcycleh_carry", last_rdata, 32'h1);
    wr(12'hB00, 32'hFFFF_FFFF); wr(12'hB80, 32'h0);
    rd(12'hB80); chk("mcycleh_before", last_rdata, 32'h0);
    rd(12'hB00); chk("mcycle_wrapped", last_rdata, 32'h0);

    // instret counter
    wr(12'hB02, 32'h10);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    rd(12'hC02); chk("instret_shadow", last_rdata, 32'h11);

    // trap collides with software writes
    cyc(0, 0, 1, 12'h341, 32'h0000_4000, 0, 1, 32'h0000_5678, 32'h7, 32'h0, 0);
    chk("trap_beats_mepc_write", bus.mepc_o, 32'h0000_5678);
    cyc(0, 0, 1, 12'h340, 32'hA5A5_5A5A, 0, 1, 32'h0000_9000, 32'h3, 32'h0, 0);
    rd(12'h340); chk("mscratch_with_trap", last_rdata, 32'hA5A5_5A5A);

    // illegal accesses
    wr(12'hC00, 32'h1234_5678);
    chk("illegal_ro_write", 32'(bus.illegal_o), 32'h1);
    rd(12'h7C0); chk("illegal_read_data", last_rdata, 32'h0);
    chk("illegal_read_flag", 32'(bus.illegal_o), 32'h1);
    rd(12'hC80); chk("cycleh_unchanged", last_rdata, 32'h1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 19)],
          1'($urandom_range(0, 2) == 0), addr_tab[$urandom_range(0, 19)], $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), $urandom, $urandom,
          $urandom, 1'($urandom_range(0, 9) == 0));
    end

    // reset asserted mid-trap: state clears without a clock edge
    wr(12'h305, 32'h0000_2000);
    wr(12'h304, 32'h0000_0008);
    wr(12'h300, 32'h0000_0008);
    bus.trap_i = 1; bus.trap_pc_i = 32'h0000_7770; bus.trap_cause_i = 32'h5;
    bus.re_i = 1; bus.raddr_i = 12'h342;
    #2;
    rst_n = 0;
    #1;
    chk("async_mtvec_o", bus.mtvec_o, 32'h0);
    chk("async_mepc_o", bus.mepc_o, 32'h0);
    chk("async_mie_o", bus.mie_o, 32'h0);
    chk("async_mstatus_mie_o", 32'(bus.mstatus_mie_o), 32'h0);
    chk("async_mcause", bus.rdata_o, 32'h0);
    @(posedge clk);
    #1;
    chk("reset_hold_mcause", bus.rdata_o, 32'h0);
    drive_idle();
    rst_n = 1;
    m_reset();
    rd(12'hB00); chk("mcycle_after_rerelease", last_rdata, 32'h0);
    rd(12'h341); chk("mepc_after_rerelease", last_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/csr_reg_file.md
CSR_REG_FILE -- requirements
Module: csr_reg_file

Interface
REQ-001 SHALL have port clk_i, input, 1: single clock, rising-edge.
REQ-002 SHALL have port rst_n_i, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port re_i, input, 1: CSR read access valid this cycle.
REQ-004 SHALL have port raddr_i, input, 12: CSR read address (inst[31:20]).
REQ-005 SHALL have port rdata_o, output, 32: CSR read data, combinational from raddr_i; feeds execute-stage csr_rdata input.
REQ-006 SHALL have port we_i, input, 1: CSR write enable from writeback.
REQ-007 SHALL have port waddr_i, input, 12: CSR write address.
REQ-008 SHALL have port wdata_i, input, 32: write value already merged by execute (RW/RS/RC).
REQ-009 SHALL have port instret_i, input, 1: one instruction retired this cycle.
REQ-010 SHALL have port trap_i, input, 1: trap entry pulse.
REQ-011 SHALL have ports trap_pc_i, trap_cause_i and trap_tval_i, input, 32 each: faulting PC, cause and tval.
REQ-012 SHALL have port mret_i, input, 1: MRET retire pulse.
REQ-013 SHALL have ports mtvec_o and mepc_o, output, 32 each: registered trap vector and return PC.
REQ-014 SHALL have port mstatus_mie_o, output, 1: global interrupt enable.
REQ-015 SHALL have port mie_o, output, 32: interrupt enable mask.
REQ-016 SHALL have port illegal_o, output, 1: (re_i or we_i) targets an unimplemented address, or we_i targets a read-only address; combinational.

Function
REQ-017 SHALL implement the following address map:
- mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305.
- mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
- mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.
- Read-only: cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82.
REQ-018 SHALL return 32'h0 on rdata_o for unimplemented addresses, or when re_i=0.
REQ-019 SHALL implement mstatus fields:
- MIE bit3 and MPIE bit7 writable.
- MPP[12:11] reads 2'b11.
- All other bits read 0, writes ignored.
REQ-020 SHALL read misa as constant 32'h40000100; writes ignored, not illegal.
REQ-021 SHALL implement only mie bits 3, 7 and 11; other bits read 0.
REQ-022 SHALL force mtvec[1:0] and mepc[1:0] to 0 on write (direct mode, aligned).
REQ-023 SHALL make mscratch, mcause and mtval fully 32-bit writable.
REQ-024 SHALL apply software writes at the rising edge; reads in the same cycle return the pre-write value (no bypass).
REQ-025 SHALL increment the 64-bit mcycle every cycle out of reset, wrapping from all-ones to 0.
REQ-026 SHALL increment the 64-bit minstret when instret_i=1, wrapping likewise.
REQ-027 SHALL handle counter writes as follows:
- Writing a low or high half loads that half.
- The other half holds its current value.
- No increment occurs that cycle.
- Carry from the low half into the high half is propagated only on increment.
REQ-028 SHALL, on trap_i, in one cycle:
- mepc <= {trap_pc_i[31:2], 2'b00}; mcause <= trap_cause_i; mtval <= trap_tval_i.
- MPIE <= MIE; MIE <= 0.
REQ-029 SHALL, on mret_i, set MIE <= MPIE and MPIE <= 1.
REQ-030 SHALL apply priority trap_i > mret_i > software write to any field touched by more than one source in the same cycle; untouched registers still accept the software write.
REQ-031 SHALL register mtvec_o, mepc_o, mstatus_mie_o and mie_o so they reflect the updated value one cycle after the update edge.
REQ-032 SHALL guarantee that an illegal write changes no state.

Reset
REQ-033 SHALL, on rst_n_i=0 asynchronously:
- Clear mstatus (MIE=0, MPIE=0), mie, mtvec, mscratch, mepc, mcause, mtval, mcycle and minstret to 0.
- Drive mtvec_o, mepc_o, mie_o and mstatus_mie_o to 0.
REQ-034 SHALL have mcycle read 0 in the first cycle after reset release and 1 in the next.
REQ-035 SHALL abort any in-flight trap_i, mret_i or write on reset assertion; nothing is committed.

Verification
REQ-036 SHALL cover: write 0x300 = 0x0000_0088 -> read 0x300 returns 0x0000_1888; mstatus_mie_o=1 next cycle.
REQ-037 SHALL cover: MIE=1, trap_i with pc 0x0000_1236, cause 0x0000_0002, tval 0xDEAD_BEEF -> mepc=0x0000_1234, MIE=0, MPIE=1, mcause=2, mtval=0xDEADBEEF; then mret_i -> MIE=1, MPIE=1.
REQ-038 SHALL cover: write mcycle=0xFFFF_FFFF, mcycleh=0 -> after 2 cycles read mcycleh=1, mcycle=0x0000_0000.
REQ-039 SHALL cover: trap_i and we_i to mepc (0x0000_4000) in the same cycle -> mepc equals the trap PC; we_i to mscratch in the same cycle as trap_i -> mscratch updated.
REQ-040 SHALL cover: we_i to 0xC00, or re_i to 0x7C0 -> illegal_o=1, rdata_o=0, no state change.
REQ-041 SHALL cover: rst_n_i pulsed low mid-trap -> all registers 0 immediately, with no clock edge required.
